// File: rtl/serial_summator_pkg.sv
// Shared types and helpers for the bit-serial unsigned adder.
package serial_summator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit counter width: wide enough to count up to len without wrapping.
   function automatic int unsigned cnt_width(input int unsigned len);
      int unsigned w;
      w = $clog2(len + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_full_adder_bit.sv
// Combinational 1-bit full adder used as the serial datapath slice.
module serial_full_adder_bit (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   assign s_o    = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_summator.sv
// Bit-serial unsigned adder: each reset release captures r1/r2 once, adds LSB-first,
// and presents the registered (reglength+1)-bit sum with done.
module serial_summator
   import serial_summator_pkg::*;
#(
   parameter int unsigned reglength = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [reglength-1:0] r1,
   input  logic [reglength-1:0] r2,
   output logic [reglength:0]   sum,
   output logic                 done
);

   localparam int unsigned CW = cnt_width(reglength);

   state_e               state_q, state_d;
   logic [reglength-1:0] a_q, a_d;
   logic [reglength-1:0] b_q, b_d;
   logic [reglength-1:0] acc_q, acc_d;
   logic                 carry_q, carry_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [reglength:0]   sum_q, sum_d;
   logic                 done_q, done_d;

   logic                 fa_s;
   logic                 fa_cout;
   logic [reglength:0]   acc_shift;

   serial_full_adder_bit u_fa (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .cin_i  (carry_q),
      .s_o    (fa_s),
      .cout_o (fa_cout)
   );

   // New result bit enters from the MSB side of the accumulator.
   assign acc_shift = {fa_s, acc_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      done_d  = done_q;

      case (state_q)
         IDLE: begin
            a_d     = r1;
            b_d     = r2;
            acc_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
            state_d = ADD;
         end
         ADD: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = acc_shift[reglength:1];
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            // Last operand bit: publish the full sum in the same edge.
            if (cnt_q == CW'(reglength - 1)) begin
               sum_d   = {fa_cout, acc_shift[reglength:1]};
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sum  = sum_q;
   assign done = done_q;

endmodule

// File: tb/tb_serial_summator.sv
// Self-checking bench for serial_summator: directed cases, exhaustive pairs, and
// randomized runs compared against plain integer addition.
module tb_serial_summator;

   localparam int unsigned RL = 3;
   localparam int unsigned SW = RL + 1;

   logic          clk;
   logic          reset;
   logic [RL-1:0] r1;
   logic [RL-1:0] r2;
   logic [SW-1:0] sum;
   logic          done;

   int checks;
   int errors;

   serial_summator #(.reglength(RL)) dut (
      .clk   (clk),
      .reset (reset),
      .r1    (r1),
      .r2    (r2),
      .sum   (sum),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   // Hold reset, release with operands a/b, check the 4-edge latency and the result.
   task automatic run_add(input int unsigned a, input int unsigned b, input bit scramble);
      int unsigned exp;
      reset = 1'b0;
      r1    = RL'(a);
      r2    = RL'(b);
      repeat (4) edge_wait();
      chk("rst_sum", 32'(sum), 0);
      chk("rst_done", 32'(done), 0);
      reset = 1'b1;
      exp   = a + b;
      for (int e = 1; e <= int'(RL) + 1; e++) begin
         edge_wait();
         if (scramble) begin
            r1 = RL'($urandom);
            r2 = RL'($urandom);
         end
         if (e <= int'(RL)) begin
            chk("busy_sum", 32'(sum), 0);
            chk("busy_done", 32'(done), 0);
         end else begin
            chk("result_sum", 32'(sum), exp);
            chk("result_done", 32'(done), 1);
         end
      end
   endtask

   initial begin
      int unsigned a;
      int unsigned b;
      int unsigned k;
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      r1     = 3'd5;
      r2     = 3'd3;

      // Reset hold: outputs stay clear while reset is low.
      for (int i = 0; i < 4; i++) begin
         edge_wait();
         chk("hold_sum", 32'(sum), 0);
         chk("hold_done", 32'(done), 0);
      end

      run_add(2, 3, 1'b0);
      // Asynchronous clear mid-cycle, no clock edge in between.
      #2;
      reset = 1'b0;
      #1;
      chk("async_sum", 32'(sum), 0);
      chk("async_done", 32'(done), 0);

      run_add(7, 7, 1'b0);
      run_add(7, 1, 1'b0);

      // Operand change after capture must not affect the result; DONE holds.
      reset = 1'b0;
      r1 = 3'd4;
      r2 = 3'd1;
      repeat (2) edge_wait();
      reset = 1'b1;
      edge_wait();
      edge_wait();
      r1 = 3'd0;
      r2 = 3'd0;
      edge_wait();
      chk("chg_busy_done", 32'(done), 0);
      edge_wait();
      chk("chg_sum", 32'(sum), 5);
      chk("chg_done", 32'(done), 1);
      for (int i = 0; i < 12; i++) begin
         r1 = RL'($urandom);
         r2 = RL'($urandom);
         edge_wait();
         chk("hold_done_sum", 32'(sum), 5);
         chk("hold_done_flag", 32'(done), 1);
      end

      // Abort mid-addition, then restart cleanly.
      reset = 1'b0;
      r1 = 3'd6;
      r2 = 3'd6;
      repeat (2) edge_wait();
      reset = 1'b1;
      repeat (2) edge_wait();
      reset = 1'b0;
      #1;
      chk("abort_sum", 32'(sum), 0);
      chk("abort_done", 32'(done), 0);
      run_add(1, 2, 1'b0);

      // Short releases: fewer than RL+1 edges never produce a result.
      for (int t = 0; t < 6; t++) begin
         k = $urandom_range(RL, 1);
         reset = 1'b0;
         r1 = RL'($urandom);
         r2 = RL'($urandom);
         repeat (2) edge_wait();
         reset = 1'b1;
         for (int e = 0; e < int'(k); e++) begin
            edge_wait();
            chk("short_sum", 32'(sum), 0);
            chk("short_done", 32'(done), 0);
         end
         reset = 1'b0;
         #1;
         chk("short_rst_done", 32'(done), 0);
      end

      // Exhaustive operand pairs.
      for (int i = 0; i < (1 << RL); i++) begin
         for (int j = 0; j < (1 << RL); j++) begin
            run_add(i, j, 1'b0);
         end
      end

      // Random operands with noise on the inputs after capture.
      for (int t = 0; t < 20; t++) begin
         a = $urandom_range((1 << RL) - 1, 0);
         b = $urandom_range((1 << RL) - 1, 0);
         run_add(a, b, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_summator.md
Name: serial_summator

Overview:
- Bit-serial unsigned adder. Captures two reglength-bit operands after reset is released, adds them LSB-first one bit per clock, and presents the (reglength+1)-bit sum with a done flag.
- Small, area-lean arithmetic leaf. A new addition is started by pulsing reset low, so every reset release begins exactly one computation.

Parameters:
- reglength, 3, operand width in bits (≥1); sum width is reglength+1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; also acts as the "start new addition" control.
- r1  input  reglength  operand A, unsigned.
- r2  input  reglength  operand B, unsigned.
- sum  output  reglength+1  registered result r1+r2, including carry-out as MSB.
- done  output  1  high while sum holds a valid result.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset=0 resets immediately, without waiting for a clock edge).
- While reset=0, all state clears immediately:
  - FSM=IDLE, sum=0, done=0.
  - Operand shift registers=0, carry=0, bit counter=0.
- States:
  - IDLE: the first rising edge after reset goes high captures r1, r2 into shift registers, clears carry and counter, and moves to ADD.
  - ADD: each edge computes one full-adder step on the registered LSBs plus carry. The result bit shifts into the accumulator from the MSB side, the operand registers shift right by 1, carry updates, and the counter increments.
  - ADD → DONE: after reglength ADD edges. On that final edge, sum <= {carry_out, accumulated bits} and done <= 1.
  - DONE: holds sum and done until the next reset assertion. Operand changes are ignored.
- Latency: sum/done are valid after exactly reglength+1 rising edges following reset release (4 edges for reglength=3).
- sum stays 0 and done stays 0 throughout IDLE/ADD. There are no intermediate partial values on sum.
- Operands are sampled only once, at the IDLE edge. Changes during ADD/DONE do not affect the result.
- Arithmetic: unsigned, no overflow loss. Maximum result is 2*(2^reglength−1), e.g. 7+7=14 for reglength=3.
- Reset mid-operation (in ADD or DONE): aborts the addition immediately. The next release restarts from IDLE.
- Reset released for fewer than reglength+1 edges: done never rises and sum stays 0.
- Counter width: clog2(reglength+1); it must not wrap before reaching reglength.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, ADD, DONE).
  - A function computing the counter width from reglength.
- One natural sub-module: serial_full_adder_bit. It is a combinational 1-bit full adder (a, b, cin → s, cout), instantiated once in the datapath.
- The FSM, shift registers and result register live in serial_summator.

Test Plan:
- Reset hold: reset=0 for 4 cycles with r1=5, r2=3 → sum=0, done=0 throughout; immediate clear when reset asserts mid-cycle.
- Basic add (reglength=3): r1=2, r2=3, release reset → sum=5 (4'b0101) with done=1 on the 4th rising edge after release; sum=0 on edges 1–3.
- Carry-out: r1=7, r2=7 → sum=14 (4'b1110); r1=7, r2=1 → sum=8 (4'b1000).
- Operand change after capture: r1=4, r2=1 at release, then change to r1=0, r2=0 on edge 2 → sum=5, held stable in DONE for 10+ cycles.
- Abort: release with r1=6, r2=6; assert reset at edge 2 → sum=0, done=0. Release again with r1=1, r2=2 → sum=3 after 4 edges.
- Exhaustive: all 64 pairs of r1, r2 in 0..7, each with reset low 4 cycles then high 4 cycles → sum equals r1+r2 and done=1 on the 4th edge every time.
